// File: rtl/ysyx_22041211_defines.sv
// Shared IFU definitions: fetch FSM state encoding and instruction error codes.
package ysyx_22041211_defines;

    typedef enum logic [1:0] {
        IFU_REQ  = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_HOLD = 2'd2
    } ifu_state_e;

    localparam logic INST_ERR_NONE     = 1'b0;
    localparam logic INST_ERR_MISALIGN = 1'b1;

    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_22041211_Reg.sv
// Generic hold register: synchronous active-high reset to RESET_VAL, load on wen.
// One cycle from wen to dout; no flow control of its own.
module ysyx_22041211_Reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= RESET_VAL;
        end else if (wen) begin
            dout_q <= din;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch: REQ -> WAIT -> HOLD, 3 cycles per instruction at best; a misaligned PC
// skips memory and presents an error instruction. Stalls on mem_req_ready, mem_rsp_valid and inst_ready.
module ysyx_22041211_ifu
    import ysyx_22041211_defines::*;
#(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] pc,
    output logic                pc_en,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_LEN-1:0] mem_req_addr,
    input  logic                mem_rsp_valid,
    input  logic [DATA_LEN-1:0] mem_rsp_data,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [DATA_LEN-1:0] inst,
    output logic [ADDR_LEN-1:0] inst_pc,
    output logic                inst_err
);

    ifu_state_e          state_q;
    logic                misaligned;
    logic                in_req;
    logic                in_wait;
    logic                in_hold;
    logic                err_load;
    logic                pc_wen;
    logic                data_wen;
    logic [DATA_LEN-1:0] inst_d;
    logic                inst_err_d;

    assign misaligned = pc_misaligned(pc[1:0]);

    // Handshake outputs are gated by rst so nothing leaks out while the FSM is being cleared.
    assign in_req  = !rst && (state_q == IFU_REQ);
    assign in_wait = !rst && (state_q == IFU_WAIT);
    assign in_hold = !rst && (state_q == IFU_HOLD);

    assign mem_req_valid = in_req && !misaligned;
    assign mem_req_addr  = pc;
    assign inst_valid    = in_hold;
    assign pc_en         = in_hold && inst_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IFU_REQ;
        end else begin
            case (state_q)
                IFU_REQ: begin
                    if (misaligned) begin
                        state_q <= IFU_HOLD;
                    end else if (mem_req_ready) begin
                        state_q <= IFU_WAIT;
                    end
                end
                IFU_WAIT: begin
                    if (mem_rsp_valid) begin
                        state_q <= IFU_HOLD;
                    end
                end
                IFU_HOLD: begin
                    if (inst_ready) begin
                        state_q <= IFU_REQ;
                    end
                end
                default: state_q <= IFU_REQ;
            endcase
        end
    end

    // inst_pc is captured when the fetch leaves REQ, so it always names the word being held.
    assign err_load   = in_req && misaligned;
    assign pc_wen     = in_req && (misaligned || mem_req_ready);
    assign data_wen   = err_load || (in_wait && mem_rsp_valid);
    assign inst_d     = err_load ? '0 : mem_rsp_data;
    assign inst_err_d = err_load ? INST_ERR_MISALIGN : INST_ERR_NONE;

    ysyx_22041211_Reg #(
        .WIDTH     (DATA_LEN),
        .RESET_VAL ('0)
    ) u_inst_reg (
        .clk  (clk),
        .rst  (rst),
        .wen  (data_wen),
        .din  (inst_d),
        .dout (inst)
    );

    ysyx_22041211_Reg #(
        .WIDTH     (ADDR_LEN),
        .RESET_VAL ('0)
    ) u_inst_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .wen  (pc_wen),
        .din  (pc),
        .dout (inst_pc)
    );

    ysyx_22041211_Reg #(
        .WIDTH     (1),
        .RESET_VAL (INST_ERR_NONE)
    ) u_inst_err_reg (
        .clk  (clk),
        .rst  (rst),
        .wen  (data_wen),
        .din  (inst_err_d),
        .dout (inst_err)
    );

endmodule

// File: doc/ysyx_22041211_ifu.md
YSYX_22041211_IFU -- requirements
Module: ysyx_22041211_ifu

Interface
REQ-001 Parameter ADDR_LEN, default 32, SHALL set the width of PC and memory address.
REQ-002 Parameter DATA_LEN, default 32, SHALL set the width of instruction and memory data.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 pc  input  ADDR_LEN  SHALL be the current PC from the PC register.
REQ-006 pc_en  output  1  SHALL be the PC-register write enable: advance to next PC.
REQ-007 mem_req_valid  output  1  SHALL flag a valid fetch request.
REQ-008 mem_req_ready  input  1  SHALL flag that memory accepts the request.
REQ-009 mem_req_addr  output  ADDR_LEN  SHALL be the fetch address.
REQ-010 mem_rsp_valid  input  1  SHALL flag valid read data.
REQ-011 mem_rsp_data  input  DATA_LEN  SHALL be the fetched word.
REQ-012 inst_valid  output  1  SHALL flag a valid instruction to decode.
REQ-013 inst_ready  input  1  SHALL flag that decode accepts the instruction.
REQ-014 inst  output  DATA_LEN  SHALL be the held instruction word.
REQ-015 inst_pc  output  ADDR_LEN  SHALL be the PC of the held instruction.
REQ-016 inst_err  output  1  SHALL flag a misaligned-fetch instruction.

Function
REQ-017 The FSM SHALL have three states: REQ, WAIT, HOLD.
REQ-018 In REQ with pc[1:0]==0: mem_req_valid=1 and mem_req_addr=pc; when mem_req_ready=1, latch inst_pc<=pc and go to WAIT; otherwise stay in REQ with address stable.
REQ-019 In REQ with pc[1:0]!=0: no memory request; latch inst_pc<=pc, inst<=0, inst_err<=1 and go to HOLD.
REQ-020 mem_rsp_valid SHALL be ignored in REQ and HOLD; the response may arrive no earlier than the cycle after acceptance.
REQ-021 In WAIT on mem_rsp_valid=1: latch inst<=mem_rsp_data, inst_err<=0 and go to HOLD; otherwise stay in WAIT.
REQ-022 In HOLD: inst_valid=1 with inst, inst_pc and inst_err stable until the handshake.
REQ-023 In HOLD with inst_ready=1: pc_en=1 for exactly that cycle (combinational) and go to REQ; the new PC is used from the next cycle.
REQ-024 pc_en SHALL be 0 in all other cycles; at most one pc_en per fetched instruction.
REQ-025 Minimum throughput with zero-wait memory and decode: one instruction every 3 cycles (REQ, WAIT, HOLD).
REQ-026 mem_req_valid and inst_valid SHALL be mutually exclusive.
REQ-027 The PC address SHALL be used unmodified; there is no wrap handling (0xFFFF_FFFC fetches normally).

Reset
REQ-028 Under rst=1: state<=REQ, inst<=0, inst_pc<=0, inst_err<=0; pc_en, mem_req_valid and inst_valid SHALL be 0 while rst=1.
REQ-029 Reset in WAIT or HOLD SHALL abandon the fetch; no pc_en SHALL be issued for it.
REQ-030 The first request SHALL be issued in the first cycle after rst deasserts, at the PC register reset value (0x8000_0000).

Structure
REQ-031 State encodings and the misalignment error constant SHALL live in the shared defines file (ysyx_22041211_defines).
REQ-032 The inst, inst_pc and inst_err hold registers SHALL use the existing ysyx_22041211_Reg sub-module; the FSM stays in the top module.

Verification
REQ-033 Reset release, pc=0x8000_0000, ready/rsp immediate, rsp_data=0x0000_0413 -> inst_valid in cycle 3 with inst=0x0000_0413 and inst_pc=0x8000_0000; pc_en pulses once when inst_ready=1.
REQ-034 mem_req_ready held low for 4 cycles -> mem_req_valid=1 with addr stable for 5 cycles, then WAIT.
REQ-035 inst_ready low for 3 cycles in HOLD -> inst and inst_pc stable, pc_en=0, no new request issued.
REQ-036 pc=0x8000_0002 -> no mem_req_valid, inst_valid with inst_err=1 and inst=0; pc_en on handshake.
REQ-037 rst asserted in WAIT, then a late mem_rsp_valid arrives -> response ignored, no pc_en, fresh request after reset.
REQ-038 Stream of 10 back-to-back fetches, PC register incrementing by 4 -> 10 pc_en pulses, inst_pc sequence 0x8000_0000..0x8000_0024, 30 cycles total.
